// File: rtl/gf2m_poly_reducer.sv
// Digit-serial reduction of an IN_W-bit GF(2)[x] product modulo f(x) = x^M + POLY, D bits per clock.
// Optional macro GF_REDUCE_EARLY_EXIT_EN: finish as soon as every term at or above x^M is gone.
module gf2m_poly_reducer #(
    parameter int            IN_W = 512,
    parameter int            M    = 256,
    parameter logic [M-1:0]  POLY = 256'h425,
    parameter int            D    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [M-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);
    localparam int NUM_DIGITS = (IN_W - M) / D;
    localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(IN_W);
    localparam logic [KW-1:0]   K_LAST   = KW'(NUM_DIGITS - 1);
    localparam logic [IN_W-1:0] ONE      = IN_W'(1);
    localparam logic [IN_W-1:0] POLY_EXT = {{(IN_W - M){1'b0}}, POLY};

    typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

    state_t          state_reg, state_next;
    logic [IN_W-1:0] w_reg, w_next;
    logic [KW-1:0]   k_reg, k_next;
    logic [M-1:0]    out_data_reg, out_data_next;
    logic [PW-1:0]   top_bit;
    logic [IN_W-1:0] w_red;

    assign top_bit = PW'(IN_W - 1 - int'(k_reg) * D);

    // Bit chain, highest first: a fold from bit p lands strictly below p, so later
    // (lower) bits of the same digit already see it.
    for (genvar gi = 0; gi < D; gi++) begin : g_bit
        logic [IN_W-1:0] w_in;
        logic [IN_W-1:0] w_out;
        logic [PW-1:0]   p_bit;
        if (gi == 0) begin : g_first
            assign w_in = w_reg;
        end else begin : g_chain
            assign w_in = g_bit[gi-1].w_out;
        end
        assign p_bit = top_bit - PW'(gi);
        assign w_out = w_in[p_bit]
            ? (w_in ^ (ONE << p_bit) ^ (POLY_EXT << (p_bit - PW'(M))))
            : w_in;
    end

    assign w_red = g_bit[D-1].w_out;

`ifdef GF_REDUCE_EARLY_EXIT_EN
    // Bits above the current digit are already clear, so the whole upper part can be tested.
    logic upper_zero;
    assign upper_zero = ~|w_reg[IN_W-1:M];
`endif

    always_comb begin
        state_next    = state_reg;
        w_next        = w_reg;
        k_next        = k_reg;
        out_data_next = out_data_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    w_next     = in_data;
                    k_next     = '0;
                    state_next = REDUCE;
                end
            end
            REDUCE: begin
`ifdef GF_REDUCE_EARLY_EXIT_EN
                if (upper_zero) begin
                    state_next    = DONE;
                    out_data_next = w_reg[M-1:0];
                end else
`endif
                begin
                    w_next = w_red;
                    k_next = k_reg + 1'b1;
                    if (k_reg == K_LAST) begin
                        state_next    = DONE;
                        out_data_next = w_red[M-1:0];
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next    = IDLE;
                    out_data_next = '0;
                end
            end
            default: begin
                state_next    = IDLE;
                out_data_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            w_reg        <= '0;
            k_reg        <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            w_reg        <= w_next;
            k_reg        <= k_next;
            out_data_reg <= out_data_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out_data  = out_data_reg;
endmodule

// File: tb/tb_gf2m_poly_reducer.sv
// Bench for gf2m_poly_reducer: long-division reference model, per-cycle compare, directed and random traffic.
// Honours GF_REDUCE_EARLY_EXIT_EN when computing expected latency.
module tb_gf2m_poly_reducer;
    localparam int IN_W = 512;
    localparam int M    = 256;
    localparam int D    = 8;
    localparam int ND   = (IN_W - M) / D;
    localparam logic [M-1:0] POLY = 256'h425;
`ifdef GF_REDUCE_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [IN_W-1:0] in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [M-1:0]    out_data;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            busy;

    gf2m_poly_reducer #(.IN_W(IN_W), .M(M), .POLY(POLY), .D(D)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Remainder by schoolbook long division; qlow is the lowest quotient term (-1 if none).
    function automatic logic [M-1:0] ref_reduce(input logic [IN_W-1:0] x, output int qlow);
        logic [IN_W-1:0] r;
        r = x;
        qlow = -1;
        for (int p = IN_W - 1; p >= M; p--) begin
            if (r[p]) begin
                r[p] = 1'b0;
                r = r ^ ({{(IN_W - M){1'b0}}, POLY} << (p - M));
                qlow = p;
            end
        end
        return r[M-1:0];
    endfunction

    // Digits that must be processed = digit holding the lowest quotient term; one more edge to notice zero.
    function automatic int exp_lat(input int qlow);
        int d;
        d = (qlow < 0) ? 0 : (IN_W - 1 - qlow) / D + 1;
        if (EARLY) return (d + 1 < ND) ? d + 1 : ND;
        return ND;
    endfunction

    function automatic logic [IN_W-1:0] clmul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [IN_W-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++)
            if (a[i]) r = r ^ ({{(IN_W - M){1'b0}}, b} << i);
        return r;
    endfunction

    function automatic logic [M-1:0] rand_m();
        logic [M-1:0] v;
        for (int i = 0; i < M / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Transaction-level model: idle -> busy for m_lat edges -> holding result until out_ready.
    bit           m_active = 1'b0;
    bit           m_valid = 1'b0;
    int           m_rem = 0;
    int           m_lat = 0;
    logic [M-1:0] m_res = '0;
    int           cyc = 0;
    int           last_acc_cyc = -1;
    int           last_lat = 0;
    bit           b2b = 1'b0;
    int           b2b_acc = 0;
    int           b2b_out = 0;

    always @(negedge clk) begin
        int q;
        cyc++;
        if (!rst) begin
            m_active = 1'b0;
            m_valid = 1'b0;
            m_rem = 0;
            last_acc_cyc = -1;
            check("rst_in_ready", IN_W'(in_ready), IN_W'(1'b1));
            check("rst_busy", IN_W'(busy), IN_W'(1'b0));
            check("rst_out_valid", IN_W'(out_valid), IN_W'(1'b0));
            check("rst_out_data", IN_W'(out_data), '0);
        end else begin
            check("in_ready", IN_W'(in_ready), IN_W'(!m_active));
            check("busy", IN_W'(busy), IN_W'(m_active));
            check("out_valid", IN_W'(out_valid), IN_W'(m_valid));
            check("out_data", IN_W'(out_data), IN_W'(m_valid ? m_res : {M{1'b0}}));
            if (!m_active) begin
                if (in_valid) begin
                    m_res = ref_reduce(in_data, q);
                    m_lat = exp_lat(q);
                    m_rem = m_lat;
                    m_active = 1'b1;
                    if (b2b) begin
                        b2b_acc++;
                        if (last_acc_cyc >= 0)
                            check("accept_spacing", IN_W'(cyc - last_acc_cyc), IN_W'(last_lat + 2));
                    end
                    last_acc_cyc = b2b ? cyc : -1;
                    last_lat = m_lat;
                end
            end else if (!m_valid) begin
                m_rem--;
                if (m_rem == 0) m_valid = 1'b1;
            end else if (out_ready) begin
                m_active = 1'b0;
                m_valid = 1'b0;
                if (b2b) b2b_out++;
            end
        end
    end

    task automatic send(input logic [IN_W-1:0] data);
        bit ok;
        ok = 1'b0;
        in_data = data;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_timeout("accept");
        #1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) fail_timeout("out_valid");
    endtask

    task automatic directed(input string name, input logic [IN_W-1:0] data,
                            input logic [M-1:0] exp, input int exp_l);
        int lat;
        out_ready = 1'b1;
        send(data);
        in_valid = 1'b0;
        wait_out(lat);
        $display("op %s latency=%0d out_data=%0h", name, lat, out_data);
        check({name, "_latency"}, IN_W'(lat), IN_W'(exp_l));
        check({name, "_data"}, IN_W'(out_data), IN_W'(exp));
        @(posedge clk);
        #1;
    endtask

    logic [M-1:0]    held;
    logic [M-1:0]    ra, rb;
    logic [IN_W-1:0] one_w;
    int              qtmp;
    int              lat_bp;

    initial begin
        one_w = IN_W'(1);
        // Pin the reference model with hand-derived remainders.
        check("model_x0", IN_W'(ref_reduce(one_w, qtmp)), IN_W'(1));
        check("model_x256", IN_W'(ref_reduce(one_w << 256, qtmp)), IN_W'(256'h425));
        check("model_x511", IN_W'(ref_reduce(one_w << 511, qtmp)), IN_W'((256'h1 << 255) | 256'h8001A));
        check("model_x300", IN_W'(ref_reduce(one_w << 300, qtmp)), IN_W'(256'h425 << 44));

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        directed("x0", one_w, 256'h1, EARLY ? 1 : ND);
        directed("x256", one_w << 256, 256'h425, ND);

        // Output backpressure with ignored input pulses.
        out_ready = 1'b0;
        send(one_w << 511);
        in_valid = 1'b0;
        wait_out(lat_bp);
        held = out_data;
        $display("op bp_x511 latency=%0d out_data=%0h", lat_bp, out_data);
        check("bp_x511_data", IN_W'(out_data), IN_W'((256'h1 << 255) | 256'h8001A));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", IN_W'(out_valid), IN_W'(1'b1));
            check("bp_out_data", IN_W'(out_data), IN_W'(held));
            check("bp_in_ready", IN_W'(in_ready), IN_W'(1'b0));
            in_valid = i[0];
            in_data = clmul(rand_m(), rand_m());
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", IN_W'(out_valid), IN_W'(1'b0));
        check("bp_release_in_ready", IN_W'(in_ready), IN_W'(1'b1));

        // Asynchronous reset in the middle of a reduction.
        send(clmul(rand_m(), rand_m()));
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        $display("op async_reset busy=%0b in_ready=%0b out_valid=%0b", busy, in_ready, out_valid);
        check("arst_in_ready", IN_W'(in_ready), IN_W'(1'b1));
        check("arst_busy", IN_W'(busy), IN_W'(1'b0));
        check("arst_out_valid", IN_W'(out_valid), IN_W'(1'b0));
        check("arst_out_data", IN_W'(out_data), '0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        directed("x300", one_w << 300, 256'h425 << 44, EARLY ? 28 : ND);

        // Back-to-back random products, in_valid and out_ready held high.
        b2b = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ra = rand_m();
            rb = rand_m();
            if (i % 5 == 0) rb = {{(M - 32){1'b0}}, rb[31:0]};
            send(clmul(ra, rb));
            $display("op b2b[%0d] accepted in_data=%0h", i, in_data);
        end
        in_valid = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (!m_active) break;
        end
        b2b = 1'b0;
        check("b2b_accepts", IN_W'(b2b_acc), IN_W'(100));
        check("b2b_outputs", IN_W'(b2b_out), IN_W'(100));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/gf2m_poly_reducer.md
Name: gf2m_poly_reducer

Overview:
- Downstream stage of the 256x256 three-way Toom-Cook carry-less multiplier.
- Takes the 512-bit GF(2)[x] product and reduces it modulo a fixed irreducible polynomial f(x) = x^M + POLY.
- Returns the M-bit field element.
- Digit-serial: clears D upper bits per clock, with valid/ready handshakes on both sides.

Parameters:
- IN_W, 512, product width; bits IN_W-1..M are reduced away.
- M, 256, field degree and output width.
- POLY, 256'h425, low terms of f(x); default encodes x^256+x^10+x^5+x^2+1. deg(POLY) < M required.
- D, 8, digit size in bits cleared per REDUCE cycle. (IN_W-M) % D == 0 required.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_data  input  IN_W  unreduced product.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a product.
- out_data  output  M  reduced result, in_data mod f(x).
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in REDUCE or DONE.

Behaviour:
- Reset (rst low, asynchronous, any state including mid-reduction):
  - state=IDLE, working register w=0, digit counter k=0.
  - out_valid=0, out_data=0, in_ready=1, busy=0.
  - Any in-flight operation is discarded with no partial output.
- States IDLE, REDUCE, DONE. Registered outputs; in_ready=(state==IDLE).
- IDLE:
  - On edge with in_valid&in_ready: w<=in_data, k<=0, go to REDUCE.
  - in_valid without a handshake is ignored.
- REDUCE:
  - Each edge processes window bits p = IN_W-1-k*D down to IN_W-D-k*D, highest first.
  - For each p with w[p]=1: w ^= (1<<p) ^ (POLY<<(p-M)).
  - Terms landing inside the current digit are seen by later (lower) bits in the same cycle.
  - k<=k+1. When k reaches (IN_W-M)/D-1, go to DONE.
  - NUM_DIGITS = (IN_W-M)/D = 32 at defaults.
- DONE:
  - out_valid=1, out_data=w[M-1:0].
  - Both are held stable until out_ready is sampled high.
  - On out_valid&out_ready: out_valid<=0, go to IDLE.
  - in_ready is 0 throughout DONE, so the next product is accepted only the cycle after the output handshake.
- Latency: accept edge E0, reduction edges E1..E32, out_valid high after E32, i.e. 32 clocks at defaults.
- Throughput: one result per NUM_DIGITS+2 cycles minimum.
- Arithmetic is pure XOR (GF(2)); there are no carries.
  - Bit IN_W-1 is reduced normally even though a 256x256 product never sets it.
- out_valid never asserts without a preceding input handshake.
- out_data is 0 whenever out_valid is 0.

Optional Feature:
- Macro GF_REDUCE_EARLY_EXIT_EN.
- Defined:
  - At each REDUCE edge, if w[IN_W-1-k*D : M] is all zero before processing, go straight to DONE and leave w unchanged.
  - Latency becomes 1..NUM_DIGITS clocks, data dependent.
  - Input with upper half zero gives out_valid after E1.
- Undefined: latency is always exactly NUM_DIGITS clocks; no zero-detect logic.
- Results are identical either way.

Test Plan:
- in_data=512'h1 -> out_data=256'h1.
  - Macro off: out_valid 32 clocks after accept.
  - Macro on: out_valid 1 clock after accept.
- in_data=1<<256 -> out_data=256'h425.
- in_data=1<<511 -> out_data = (1<<255)|256'h8001A, i.e. x^255+x^19+x^4+x^3+x.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_data and out_valid stay stable; in_ready=0; in_valid pulses are ignored.
  - Raise out_ready: out_valid drops next edge; in_ready=1 the following cycle.
- Reset mid-operation: drive rst low at reduction edge E10, asynchronously between edges.
  - Outputs clear immediately; in_ready=1.
  - New in_data=1<<300 after release -> out_data=x^44+x^54+x^49+x^46 = 256'h0042500000000000 (0x425<<44).
- Back-to-back: 100 random 256x256 carry-less products with out_ready=1 and in_valid=1.
  - Every out_data matches a software modular reduction.
  - No input is dropped or duplicated.
  - Accept spacing is exactly NUM_DIGITS+2 cycles with the macro off.
